mux_nto1_reg: RTL and testbench
===============================

Name: mux_nto1_reg

Overview:
Parametrised N:1 data multiplexer with per-input valid bits and a registered output stage with valid/ready backpressure. Successor to the 2:1 4-bit valid-gated mux used in the transceiver datapath. Supports an externally selected mode and an optional round-robin arbitration mode. Sits between lane FIFOs and the serializer/demux stages.

Parameters:
WIDTH, 4, data width per input in bits (>=1)
NUM_IN, 2, number of input channels (>=2)
SEL_W, $clog2(NUM_IN), selector/grant width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-high
mode  input  1  0 = external selector, 1 = round-robin (effective only with MUX_RR_EN)
selector  input  SEL_W  channel index used in external mode
data_in  input  NUM_IN*WIDTH  packed inputs; channel i at [i*WIDTH +: WIDTH]
valid_in  input  NUM_IN  per-channel valid
ready_in  output  NUM_IN  per-channel accept; one-hot or zero
data_out  output  WIDTH  registered data
valid_out  output  1  registered valid
grant_out  output  SEL_W  registered index of the channel that produced data_out
ready_out  input  1  downstream accept

Behaviour:
- Reset is synchronous and active-high: while reset=1 at a rising clk edge, data_out=0, valid_out=0, grant_out=0, rr pointer=0. ready_in is 0 throughout reset.
- load = !valid_out || ready_out. Output register loads only when load=1; otherwise it holds all outputs.
- Grant, external mode: g = selector. If selector >= NUM_IN, there is no grant.
- Grant, round-robin mode: g = first i with valid_in[i]=1, scanning ptr, ptr+1, ... mod NUM_IN. If no input is valid, there is no grant.
- ready_in[g] = load && valid_in[g] && grant exists. All other ready_in bits are 0. ready_in is combinational from valid_in, selector, mode, ptr, valid_out and ready_out.
- Transfer on channel g: ready_in[g] && valid_in[g]. On the next edge: data_out = data_in[g], valid_out = 1, grant_out = g.
- When load=1 and there is no transfer, data_out is forced to 0 and valid_out to 0, consistent with zero-on-invalid across the codebase. grant_out holds its previous value.
- Latency: exactly 1 cycle from accepted input to valid_out.
- Throughput: 1 word/cycle while ready_out=1.
- RR pointer: after a transfer in round-robin mode, ptr = (g+1) mod NUM_IN, wrapping NUM_IN-1 -> 0. The pointer is unchanged in external mode and on idle cycles.
- Backpressure: while valid_out=1 and ready_out=0, data_out, valid_out and grant_out are stable and all ready_in bits are 0.
- Mode change mid-stream: takes effect on the same cycle's grant; the held output word is unaffected; ptr is preserved.
- Reset mid-transfer: the pending output word is discarded, not replayed.

Optional Feature:
MUX_RR_EN
- Defined: round-robin mode and the ptr register are built, and mode=1 selects round-robin.
- Not defined: mode is ignored, the block is external-select only, and no ptr logic is synthesised. Port list is identical in both builds.

Decomposition:
- Shared package mux_pkg: MODE_EXT=1'b0 and MODE_RR=1'b1 constants, and a sel_t helper width function.
- One sub-module: rr_arbiter (NUM_IN, ptr in, valid vector in, grant index + grant_valid out), instantiated only under MUX_RR_EN.

Test Plan:
- Reset with NUM_IN=2, WIDTH=4: hold reset=1 for 2 cycles with all valid_in=1 -> data_out=0, valid_out=0, grant_out=0, ready_in=2'b00.
- External mode, NUM_IN=4, selector=2, data_in[2]=4'hA, valid_in=4'b0100, ready_out=1 -> ready_in=4'b0100; next cycle data_out=4'hA, valid_out=1, grant_out=2. Then set selector=5 (with SEL_W widened to 3 via NUM_IN=5 config) on an invalid index -> next cycle valid_out=0, data_out=0.
- Selected channel invalid: selector=1, valid_in[1]=0, valid_in[0]=1 -> ready_in=0; next cycle data_out=0, valid_out=0.
- Backpressure: after loading 4'h5, hold ready_out=0 for 3 cycles while inputs change -> data_out stays 4'h5, valid_out stays 1, ready_in=0. Release -> next word loads the following cycle.
- Round-robin (MUX_RR_EN), NUM_IN=4, all valid_in=1 constant, ready_out=1 -> grant_out sequence 0,1,2,3,0. Then valid_in=4'b1001 with ptr=1 -> grant 3, then 0.
- Build without MUX_RR_EN, mode=1, selector=3 -> behaves as external select: grant_out=3, no rotation.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode constants and selector width helper for mux_nto1_reg
package mux_pkg;

    localparam logic MODE_EXT = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Width of a channel index for n channels (n >= 2, so never below 1)
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant index starting the scan at ptr
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NUM_IN = 2,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [SEL_W-1:0]  ptr,
    input  logic [NUM_IN-1:0] valid,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_valid
);

    localparam logic [SEL_W:0] NUM_IN_X = (SEL_W+1)'(NUM_IN);

    // Rotate so that bit k corresponds to channel (ptr + k) mod NUM_IN
    logic [NUM_IN-1:0] rot;
    assign rot = NUM_IN'({valid, valid} >> ptr);

    logic [SEL_W:0] sum;

    // Pick the lowest rotated offset that is valid; descending loop lets the lowest win
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        sum         = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (SEL_W+1)'(k);
                if (sum >= NUM_IN_X) begin
                    sum = sum - NUM_IN_X;
                end
                grant       = sum[SEL_W-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_reg.sv
// rtl/mux_nto1_reg.sv - N:1 valid/ready mux with registered output; MUX_RR_EN adds round-robin mode
module mux_nto1_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int NUM_IN = 2,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        selector,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [NUM_IN-1:0]       valid_in,
    output logic [NUM_IN-1:0]       ready_in,
    output logic [WIDTH-1:0]        data_out,
    output logic                    valid_out,
    output logic [SEL_W-1:0]        grant_out,
    input  logic                    ready_out
);

    localparam logic [SEL_W:0] NUM_IN_X = (SEL_W+1)'(NUM_IN);

    logic [WIDTH-1:0] ch [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign ch[i] = data_in[i*WIDTH +: WIDTH];
    end

    logic             load;
    logic             xfer;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             ext_grant_valid;

    assign load            = !valid_out || ready_out;
    assign ext_grant_valid = ({1'b0, selector} < NUM_IN_X);

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_grant_valid;
    logic [SEL_W:0]   ptr_inc;

    rr_arbiter #(
        .NUM_IN      (NUM_IN)
    ) u_rr_arbiter (
        .ptr         (ptr),
        .valid       (valid_in),
        .grant       (rr_grant),
        .grant_valid (rr_grant_valid)
    );

    // Mode picks the grant source on the same cycle it changes
    always_comb begin
        if (mode == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_grant_valid;
        end else begin
            grant       = selector;
            grant_valid = ext_grant_valid;
        end
    end

    assign ptr_inc = {1'b0, grant} + (SEL_W+1)'(1);

    // Pointer moves past the served channel only on round-robin transfers
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (xfer && (mode == MODE_RR)) begin
            ptr <= (ptr_inc == NUM_IN_X) ? '0 : ptr_inc[SEL_W-1:0];
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign grant       = selector;
    assign grant_valid = ext_grant_valid;
`endif

    assign xfer = !reset && load && grant_valid && valid_in[grant];

    // At most one channel is accepted, and only when the output stage can take it
    always_comb begin
        ready_in = '0;
        if (xfer) begin
            ready_in[grant] = 1'b1;
        end
    end

    // Output stage: load the granted word, zero on idle, hold under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            grant_out <= '0;
        end else if (load) begin
            if (xfer) begin
                data_out  <= ch[grant];
                valid_out <= 1'b1;
                grant_out <= grant;
            end else begin
                data_out  <= '0;
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb/tb_mux_nto1_reg.sv - randomized self-checking bench for mux_nto1_reg
module tb_mux_nto1_reg;

    localparam int WIDTH  = 4;
    localparam int NUM_IN = 5;
    localparam int SEL_W  = 3;
`ifdef MUX_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    mode;
    logic [SEL_W-1:0]        selector;
    logic [NUM_IN*WIDTH-1:0] data_in;
    logic [NUM_IN-1:0]       valid_in;
    logic [NUM_IN-1:0]       ready_in;
    logic [WIDTH-1:0]        data_out;
    logic                    valid_out;
    logic [SEL_W-1:0]        grant_out;
    logic                    ready_out;

    int n_checks = 0;
    int n_errors = 0;

    int m_data, m_valid, m_grant, m_ptr;

    always #5 clk = ~clk;

    mux_nto1_reg #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .selector  (selector),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .grant_out (grant_out),
        .ready_out (ready_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic run_cycle();
        int load, has_g, g, xfer, exp_ready;
        #1;
        load  = (m_valid == 0) || ready_out;
        has_g = 0;
        g     = 0;
        if (RR_EN && mode) begin
            for (int k = 0; k < NUM_IN; k++) begin
                int idx = (m_ptr + k) % NUM_IN;
                if (has_g == 0 && valid_in[idx]) begin
                    has_g = 1;
                    g     = idx;
                end
            end
        end else if (int'(selector) < NUM_IN) begin
            has_g = 1;
            g     = int'(selector);
        end
        xfer      = (!reset && load != 0 && has_g != 0 && valid_in[g]) ? 1 : 0;
        exp_ready = (xfer != 0) ? (1 << g) : 0;
        check_eq("ready_in", 32'(ready_in), 32'(exp_ready));
        @(posedge clk);
        #1;
        if (reset) begin
            m_data = 0; m_valid = 0; m_grant = 0; m_ptr = 0;
        end else if (load != 0) begin
            if (xfer != 0) begin
                m_data  = int'((data_in >> (WIDTH * g)) & 20'hF);
                m_valid = 1;
                m_grant = g;
                if (RR_EN && mode) m_ptr = (g + 1) % NUM_IN;
            end else begin
                m_data  = 0;
                m_valid = 0;
            end
        end
        check_eq("data_out", 32'(data_out), 32'(m_data));
        check_eq("valid_out", 32'(valid_out), 32'(m_valid));
        check_eq("grant_out", 32'(grant_out), 32'(m_grant));
    endtask

    initial begin
        m_data = 0; m_valid = 0; m_grant = 0; m_ptr = 0;
        reset = 1'b1; mode = 1'b0; selector = '0; ready_out = 1'b1;
        valid_in = '1; data_in = 20'hFFFFF;
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        check_eq("rst_ready", 32'(ready_in), 32'd0);
        reset = 1'b0;

        selector = 3'd2; valid_in = 5'b00100; data_in = 20'h00A00;
        run_cycle();
        check_eq("ext_data", 32'(data_out), 32'hA);
        check_eq("ext_grant", 32'(grant_out), 32'd2);

        selector = 3'd5; valid_in = 5'b11111;
        run_cycle();
        check_eq("oor_valid", 32'(valid_out), 32'd0);

        selector = 3'd1; valid_in = 5'b00001;
        run_cycle();
        check_eq("inv_valid", 32'(valid_out), 32'd0);

        selector = 3'd0; valid_in = 5'b00001; data_in = 20'h00005;
        run_cycle();
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            selector = 3'($urandom_range(0, 4));
            valid_in = 5'($urandom);
            data_in  = 20'($urandom);
            run_cycle();
            check_eq("bp_hold", 32'(data_out), 32'h5);
        end
        ready_out = 1'b1; selector = 3'd3; valid_in = 5'b01000; data_in = 20'h07000;
        run_cycle();
        run_cycle();
        check_eq("bp_release", 32'(data_out), 32'h7);

`ifdef MUX_RR_EN
        mode = 1'b1; valid_in = '1; data_in = 20'h43210;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            check_eq("rr_seq", 32'(grant_out), 32'(i % NUM_IN));
        end
        valid_in = 5'b01001;
        run_cycle();
        check_eq("rr_skip3", 32'(grant_out), 32'd3);
        run_cycle();
        check_eq("rr_wrap0", 32'(grant_out), 32'd0);
`else
        mode = 1'b1; selector = 3'd3; valid_in = '1;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check_eq("norr_grant", 32'(grant_out), 32'd3);
        end
`endif

        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom);
            selector  = 3'($urandom_range(0, 7));
            valid_in  = 5'($urandom);
            data_in   = 20'($urandom);
            ready_out = ($urandom_range(0, 3) != 0);
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
